uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Robust 8-bit UART receiver with 16x oversampling, a 2-flop input synchronizer and 3-sample majority vote.
- Optional parity check; detects framing, break and overrun conditions.
- Delivers bytes on a valid/ready handshake, holding each byte until the consumer accepts it.
- Sits at the far end of the serial link from the transmitter, either as a drop-in upgrade of the plain receiver in uart_top or as a standalone console receiver.

Parameters:
- clock_freq, 50_000_000: system clock frequency in Hz.
- baud_rate, 9600: line bit rate.
- parity_en, 0: 1 adds a parity bit between data bit 7 and the stop bit.
- parity_odd, 0: when parity is enabled, 1 selects odd parity and 0 selects even.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- rx_in, input, 1: asynchronous serial line; idles high.
- rx_data, output, 8: received byte, LSB received first.
- rx_valid, output, 1: rx_data and the status flags are valid.
- rx_ready, input, 1: consumer accepts the byte when rx_valid && rx_ready.
- frame_err, output, 1: the stop bit was sampled 0; qualified by rx_valid.
- parity_err, output, 1: parity mismatch; qualified by rx_valid; always 0 when parity_en=0.
- break_det, output, 1: data bits, parity bit (if present) and stop bit were all 0; qualified by rx_valid.
- overrun, output, 1: one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all counters=0; synchronizer flops=1; armed=0.
  - Outputs: rx_data=0x00, rx_valid=0, frame_err=0, parity_err=0, break_det=0, overrun=0.
  - Reset asserted mid-frame abandons the frame with no output.
- Tick generator: DIV = clock_freq/(baud_rate*16), truncated. DIV<1 is an elaboration error. tick pulses for 1 clk every DIV clks and is free-running outside IDLE. Its counter restarts at 0 on the IDLE->START transition.
- Synchronizer: rx_s = rx_in delayed by 2 flops. All decisions use rx_s.
- States:
  - IDLE: armed<=1 whenever rx_s=1. If armed && rx_s=0, go to START with tick_cnt=0 and armed<=0.
    - A line that is low at reset release, or stuck low after a framing error, never starts a frame until it has been seen high.
  - START: count ticks 0..15. Take samples at ticks 7, 8 and 9; maj = majority of the three.
    - At tick 9: if maj=1, this is a false start and the block returns to IDLE.
    - At tick 15: go to DATA with bit_idx=0.
  - DATA: same 16-tick bit cell and majority sampling. shift[bit_idx]<=maj at tick 9.
    - At tick 15: if bit_idx=7, go to PARITY (parity_en=1) or STOP; otherwise bit_idx+1.
  - PARITY: same sampling. perr = (^data ^ maj) != parity_odd. At tick 15, go to STOP.
  - STOP: sample maj at tick 9, then deliver immediately and return to IDLE on the same edge. The block does not wait for the end of the stop bit, which permits back-to-back frames.
- Deliver:
  - If !rx_valid or (rx_valid && rx_ready) in that cycle: load rx_data and the flags, and rx_valid<=1 on the next edge.
  - frame_err = !maj_stop.
  - break_det = frame_err && data==0 && (parity bit==0 or no parity).
  - Otherwise the new frame is discarded, the held byte and flags are kept unchanged, and overrun=1 for exactly one cycle.
- Handshake: rx_valid stays high and rx_data stays stable until rx_valid && rx_ready. rx_valid then falls on the next edge unless a delivery occurs in the same cycle, in which case the new byte replaces the old one and rx_valid stays high.
- Latency: rx_valid rises 1 clk after the STOP tick-9 clock edge, i.e. about 2 sync clks + 9.5 bit times after the line's falling edge.
- Counter widths: tick divisor counter is $clog2(DIV+1) bits; tick_cnt is 4 bits and wraps 15->0; bit_idx is 3 bits.

Decomposition:
- Package uart_pkg holds:
  - state typedef {IDLE, START, DATA, PARITY, STOP};
  - constants OS_RATE=16, SAMPLE_A=7, SAMPLE_B=8, SAMPLE_C=9, LAST_TICK=15.
- One sub-module, uart_baud_tick: parameterised by DIV, with inputs clk, rst and restart, and output tick. It is reusable by a future oversampled transmitter.

Test Plan:
All scenarios use clock_freq=3_200_000, baud_rate=100_000 (DIV=2, 32 clk per bit), rx_ready=1 unless stated.
1. Frame 0xA5 8N1 -> exactly one rx_valid pulse with rx_data=0xA5 and all flags 0; rx_valid rises 2+304+1 clks (±DIV) after the falling edge.
2. 8-clk low glitch, then a valid 0x3C frame -> no output for the glitch, then rx_data=0x3C. Also: a 1-clk dip at tick 8 inside data bit 3 of 0xFF still yields 0xFF.
3. 0x55 with stop bit 0, line then held low for 20 bit times, then high, then 0x01 -> first 0x55 with frame_err=1, no spurious frames while low, then 0x01 clean.
4. Line low for 10 bit times -> rx_data=0x00, frame_err=1, break_det=1.
5. parity_en=1, parity_odd=0: 0x07 with parity bit 1 -> parity_err=0; 0x07 with parity bit 0 -> parity_err=1.
6. rx_ready=0, frames 0x11, 0x22, 0x33 back-to-back -> rx_data holds 0x11, overrun pulses twice, then rx_ready=1 for 1 clk -> rx_valid=0. Separately, rst low mid-DATA then a fresh 0x5A -> outputs cleared and only 0x5A delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Sub-bit ticks per bit cell.
  localparam int unsigned OS_RATE = 16;

  // Ticks within a bit cell where the line is sampled, and the last tick of the cell.
  localparam logic [3:0] SAMPLE_A  = 4'd7;
  localparam logic [3:0] SAMPLE_B  = 4'd8;
  localparam logic [3:0] SAMPLE_C  = 4'd9;
  localparam logic [3:0] LAST_TICK = 4'd15;

  // Two-of-three vote used to reject single-sample noise inside a bit cell.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock tick every DIV clocks, held in phase
// by restart so the first tick after restart lands on the first free cycle.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 1");
  end

  logic [CW-1:0] cnt;

  // Divider counter: held at zero while restart is high, otherwise counts 0..DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !restart && (cnt == '0);

endmodule

// File: rtl/uart_rx_os.sv
// 8-bit UART receiver with 16x oversampling, 2-flop synchronizer, 3-sample
// majority vote, optional parity, framing/break/overrun detection and a
// valid/ready output that holds each byte until it is accepted.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned clock_freq = 50_000_000,
  parameter int unsigned baud_rate  = 9600,
  parameter bit          parity_en  = 1'b0,
  parameter bit          parity_odd = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       break_det,
  output logic       overrun
);

  localparam int unsigned DIV = clock_freq / (baud_rate * OS_RATE);

  state_t     state;
  state_t     state_nx;
  logic       sync1;
  logic       rx_s;
  logic       tick;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic       armed;
  logic [1:0] early;
  logic [7:0] shift;
  logic       par_bit;
  logic       maj;

  logic       restart;
  logic       start_go;
  logic       at_a;
  logic       at_b;
  logic       at_c;
  logic       at_last;
  logic       deliver;
  logic       can_load;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // The third vote is the live sample taken on the tick-9 cycle itself.
  assign maj = majority3(early[0], early[1], rx_s);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic; a high vote in the start cell is treated as noise.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_go) state_nx = START;
      end
      START: begin
        if (at_c && maj)  state_nx = IDLE;
        else if (at_last) state_nx = DATA;
      end
      DATA: begin
        if (at_last && (bit_idx == 3'd7)) state_nx = parity_en ? PARITY : STOP;
      end
      PARITY: begin
        if (at_last) state_nx = STOP;
      end
      STOP: begin
        if (at_c) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: tick-position strobes, start detection and the delivery strobe.
  always_comb begin
    restart  = (state == IDLE);
    start_go = (state == IDLE) && armed && !rx_s;
    at_a     = tick && (tick_cnt == SAMPLE_A);
    at_b     = tick && (tick_cnt == SAMPLE_B);
    at_c     = tick && (tick_cnt == SAMPLE_C);
    at_last  = tick && (tick_cnt == LAST_TICK);
    deliver  = (state == STOP) && at_c;
    can_load = !rx_valid || rx_ready;
  end

  // Tick and bit counters; tick_cnt wraps 15->0 into each new cell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= 4'd0;
      bit_idx  <= 3'd0;
    end else begin
      if (start_go) begin
        tick_cnt <= 4'd0;
      end else if ((state != IDLE) && tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
      if (state == START) begin
        bit_idx <= 3'd0;
      end else if ((state == DATA) && at_last) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Arming: a start edge only counts after the line has been seen high in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
    end else if (state == IDLE) begin
      if (start_go) begin
        armed <= 1'b0;
      end else if (rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Sample capture: two early votes, then data and parity bits on the voted value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      early   <= 2'b00;
      shift   <= 8'h00;
      par_bit <= 1'b0;
    end else begin
      if (at_a) early[0] <= rx_s;
      if (at_b) early[1] <= rx_s;
      if ((state == DATA) && at_c) shift[bit_idx] <= maj;
      if ((state == PARITY) && at_c) par_bit <= maj;
    end
  end

  // Output register: load on delivery when the slot is free, drop and flag overrun otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= deliver && !can_load;
      if (deliver && can_load) begin
        rx_data    <= shift;
        rx_valid   <= 1'b1;
        frame_err  <= !maj;
        parity_err <= parity_en ? (((^shift) ^ par_bit) != parity_odd) : 1'b0;
        break_det  <= !maj && (shift == 8'h00) && (!parity_en || !par_bit);
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 32 clocks per bit (DIV=2).
module tb_uart_rx_os;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       bd;
  } rec_t;

  localparam int BIT_CLKS = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line;
  logic       rx_line_p;
  logic       rx_ready;
  logic       rx_ready_p;
  logic [7:0] rx_data,   rx_data_p;
  logic       rx_valid,  rx_valid_p;
  logic       frame_err, frame_err_p;
  logic       parity_err, parity_err_p;
  logic       break_det, break_det_p;
  logic       overrun,   overrun_p;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   rise_cyc     = 0;
  int   ovr_cnt      = 0;
  logic prev_valid   = 1'b0;
  rec_t acc_q[$];
  rec_t acc_p[$];

  uart_rx_os #(
    .clock_freq(3_200_000),
    .baud_rate (100_000),
    .parity_en (1'b0),
    .parity_odd(1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .break_det (break_det),
    .overrun   (overrun)
  );

  uart_rx_os #(
    .clock_freq(3_200_000),
    .baud_rate (100_000),
    .parity_en (1'b1),
    .parity_odd(1'b0)
  ) dut_p (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_line_p),
    .rx_data   (rx_data_p),
    .rx_valid  (rx_valid_p),
    .rx_ready  (rx_ready_p),
    .frame_err (frame_err_p),
    .parity_err(parity_err_p),
    .break_det (break_det_p),
    .overrun   (overrun_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs accepted bytes, the rise time of rx_valid and overrun pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) acc_q.push_back({rx_data, frame_err, parity_err, break_det});
      if (rx_valid_p && rx_ready_p) acc_p.push_back({rx_data_p, frame_err_p, parity_err_p, break_det_p});
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (overrun) ovr_cnt++;
    end
    prev_valid = rx_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [10:0] frame8(input logic [7:0] d, input logic stop);
    return {1'b1, stop, d, 1'b0};
  endfunction

  function automatic logic [10:0] framep(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic set_line(input bit p, input logic v);
    if (p) rx_line_p = v;
    else   rx_line   = v;
  endtask

  task automatic hold_line(input bit p, input logic v, input int n);
    set_line(p, v);
    repeat (n) @(negedge clk);
  endtask

  // Drives nbits cells LSB first, each one bit time long; call aligned to a negedge.
  task automatic applyStimulus(input bit p, input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      hold_line(p, bits[i], BIT_CLKS);
    end
  endtask

  task automatic check_rec(input bit p, input string tag, input int idx,
                           input logic [7:0] d, input logic fe, input logic pe, input logic bd);
    rec_t r;
    int   n;
    n = p ? acc_p.size() : acc_q.size();
    if (idx >= n) begin
      checkOutput({tag, "_present"}, 32'd0, 32'd1);
      return;
    end
    r = p ? acc_p[idx] : acc_q[idx];
    checkOutput({tag, "_data"}, {24'd0, r.data}, {24'd0, d});
    checkOutput({tag, "_frame_err"}, {31'd0, r.fe}, {31'd0, fe});
    checkOutput({tag, "_parity_err"}, {31'd0, r.pe}, {31'd0, pe});
    checkOutput({tag, "_break_det"}, {31'd0, r.bd}, {31'd0, bd});
  endtask

  initial begin
    int m;
    int mp;
    int st;
    int lat;
    int ob;

    rst        = 1'b0;
    rx_line    = 1'b1;
    rx_line_p  = 1'b1;
    rx_ready   = 1'b1;
    rx_ready_p = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("rst_flags", {29'd0, frame_err, parity_err, break_det}, 32'd0);
    checkOutput("rst_overrun", {30'd0, overrun, overrun_p}, 32'd0);
    checkOutput("rst_p_valid", {31'd0, rx_valid_p}, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 1: clean 0xA5 frame and its latency from the falling edge
    m  = acc_q.size();
    st = cyc;
    applyStimulus(0, frame8(8'hA5, 1'b1), 10);
    hold_line(0, 1'b1, 64);
    checkOutput("t1_count", acc_q.size() - m, 32'd1);
    check_rec(0, "t1", m, 8'hA5, 1'b0, 1'b0, 1'b0);
    lat = rise_cyc - st - 1;
    checkOutput("t1_latency", (lat >= 305 && lat <= 309) ? 32'd307 : lat, 32'd307);

    // 2: short glitch is ignored, then 0x3C; then a one-clock dip in bit 3 of 0xFF
    m = acc_q.size();
    hold_line(0, 1'b0, 8);
    hold_line(0, 1'b1, 64);
    checkOutput("t2_glitch_count", acc_q.size() - m, 32'd0);
    applyStimulus(0, frame8(8'h3C, 1'b1), 10);
    hold_line(0, 1'b1, 64);
    checkOutput("t2_count", acc_q.size() - m, 32'd1);
    check_rec(0, "t2", m, 8'h3C, 1'b0, 1'b0, 1'b0);
    m = acc_q.size();
    applyStimulus(0, frame8(8'hFF, 1'b1), 4);
    hold_line(0, 1'b1, 17);
    hold_line(0, 1'b0, 1);
    hold_line(0, 1'b1, 14);
    hold_line(0, 1'b1, 5 * BIT_CLKS + 64);
    checkOutput("t2_dip_count", acc_q.size() - m, 32'd1);
    check_rec(0, "t2_dip", m, 8'hFF, 1'b0, 1'b0, 1'b0);

    // 3: framing error, line stuck low, then recovery
    m = acc_q.size();
    applyStimulus(0, frame8(8'h55, 1'b0), 10);
    hold_line(0, 1'b0, 20 * BIT_CLKS);
    hold_line(0, 1'b1, 64);
    checkOutput("t3_stuck_count", acc_q.size() - m, 32'd1);
    applyStimulus(0, frame8(8'h01, 1'b1), 10);
    hold_line(0, 1'b1, 64);
    checkOutput("t3_count", acc_q.size() - m, 32'd2);
    check_rec(0, "t3_ferr", m, 8'h55, 1'b1, 1'b0, 1'b0);
    check_rec(0, "t3_clean", m + 1, 8'h01, 1'b0, 1'b0, 1'b0);

    // 4: break, line low for ten bit times
    m = acc_q.size();
    hold_line(0, 1'b0, 10 * BIT_CLKS);
    hold_line(0, 1'b1, 64);
    checkOutput("t4_count", acc_q.size() - m, 32'd1);
    check_rec(0, "t4_break", m, 8'h00, 1'b1, 1'b0, 1'b1);

    // 5: even parity on the parity-enabled instance
    mp = acc_p.size();
    applyStimulus(1, framep(8'h07, 1'b1, 1'b1), 11);
    hold_line(1, 1'b1, 64);
    applyStimulus(1, framep(8'h07, 1'b0, 1'b1), 11);
    hold_line(1, 1'b1, 64);
    checkOutput("t5_count", acc_p.size() - mp, 32'd2);
    check_rec(1, "t5_par_ok", mp, 8'h07, 1'b0, 1'b0, 1'b0);
    check_rec(1, "t5_par_bad", mp + 1, 8'h07, 1'b0, 1'b1, 1'b0);

    // 6: consumer stalled, three back-to-back frames
    rx_ready = 1'b0;
    ob = ovr_cnt;
    applyStimulus(0, frame8(8'h11, 1'b1), 10);
    applyStimulus(0, frame8(8'h22, 1'b1), 10);
    applyStimulus(0, frame8(8'h33, 1'b1), 10);
    hold_line(0, 1'b1, 64);
    checkOutput("t6_valid_held", {31'd0, rx_valid}, 32'd1);
    checkOutput("t6_data_held", {24'd0, rx_data}, 32'h11);
    checkOutput("t6_ferr_held", {31'd0, frame_err}, 32'd0);
    checkOutput("t6_overruns", ovr_cnt - ob, 32'd2);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checkOutput("t6_valid_drop", {31'd0, rx_valid}, 32'd0);
    rx_ready = 1'b1;
    hold_line(0, 1'b1, 8);

    // 6b: reset in the middle of the data bits, then a fresh 0x5A
    m = acc_q.size();
    applyStimulus(0, frame8(8'h00, 1'b1), 4);
    rst     = 1'b0;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("t6_rst_data", {24'd0, rx_data}, 32'h00);
    checkOutput("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    hold_line(0, 1'b1, 64);
    applyStimulus(0, frame8(8'h5A, 1'b1), 10);
    hold_line(0, 1'b1, 64);
    checkOutput("t6_rst_count", acc_q.size() - m, 32'd1);
    check_rec(0, "t6_after_rst", m, 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
